parking_time_scheduler: RTL

Sequences the shared `time_calculate` subtractor for the parking controller. Keeps a free-running 8-bit time base, allocates slots on entry, and records each slot's entry time. On exit it loads `time_out`/`time_in` into the single subtractor instance and returns the parked duration through a valid/ready handshake. It sits between the gate sensors/keypad logic and the fee/display stage.

---
 rtl/parking_pkg.sv | 28 ++
 rtl/parking_time_scheduler_if.sv | 43 ++++
 rtl/parking_slot_table.sv | 91 +++++++++
 rtl/time_calculate.sv | 12 +
 rtl/parking_time_scheduler.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types, widths and helpers for the parking time scheduler slice.
package parking_pkg;

    localparam int TIME_W = 8;
    localparam logic [TIME_W-1:0] DUR_SAT = 8'hFF;
    localparam int MAX_SLOTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_EXIT_LOAD,
        ST_EXIT_SUB,
        ST_OUT_WAIT
    } park_state_e;

    // Index of the lowest clear bit; MAX_SLOTS when every bit is set.
    function automatic logic [4:0] lowest_free(input logic [MAX_SLOTS-1:0] occ_vec);
        logic [4:0] idx;
        idx = 5'(MAX_SLOTS);
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (!occ_vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_time_scheduler_if.sv
// Gate, result and status signals between the scheduler and its neighbours.
// dur_ovf exists only when PARK_OVERFLOW_EN is defined.
interface parking_time_scheduler_if #(parameter int SLOT_W = 3);
    import parking_pkg::*;

    logic              tick;
    logic              entry_req;
    logic              entry_ack;
    logic [SLOT_W-1:0] entry_slot;
    logic              full;
    logic              exit_req;
    logic [SLOT_W-1:0] exit_slot;
    logic              exit_ack;
    logic              exit_err;
    logic              dur_valid;
    logic              dur_ready;
    logic [TIME_W-1:0] dur_time;
    logic [SLOT_W-1:0] dur_slot;
    logic [TIME_W-1:0] now;
    logic [SLOT_W:0]   occupancy;
`ifdef PARK_OVERFLOW_EN
    logic              dur_ovf;
`endif

    modport master (
`ifdef PARK_OVERFLOW_EN
        input  dur_ovf,
`endif
        output tick, entry_req, exit_req, exit_slot, dur_ready,
        input  entry_ack, entry_slot, full, exit_ack, exit_err,
        input  dur_valid, dur_time, dur_slot, now, occupancy
    );

    modport slave (
`ifdef PARK_OVERFLOW_EN
        output dur_ovf,
`endif
        input  tick, entry_req, exit_req, exit_slot, dur_ready,
        output entry_ack, entry_slot, full, exit_ack, exit_err,
        output dur_valid, dur_time, dur_slot, now, occupancy
    );

endinterface

// File: rtl/parking_slot_table.sv
// Per-slot occupancy, entry timestamp and (with PARK_OVERFLOW_EN) overflow flag.
module parking_slot_table
    import parking_pkg::*;
#(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [SLOT_W-1:0] wr_slot_i,
    input  logic [TIME_W-1:0] wr_time_i,
    input  logic              clr_en_i,
    input  logic [SLOT_W-1:0] clr_slot_i,
    input  logic [SLOT_W-1:0] rd_slot_i,
    output logic [SLOTS-1:0]  occ_o,
    output logic [TIME_W-1:0] rd_time_o,
`ifdef PARK_OVERFLOW_EN
    input  logic              tick_i,
    input  logic [TIME_W-1:0] now_i,
    output logic              rd_ovf_o,
`endif
    output logic              rd_occ_o
);

    logic [SLOTS-1:0]  occ_q;
    logic [TIME_W-1:0] entry_time_q [SLOTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_en_i && wr_slot_i == SLOT_W'(i)) begin
                    occ_q[i] <= 1'b1;
                end else if (clr_en_i && clr_slot_i == SLOT_W'(i)) begin
                    occ_q[i] <= 1'b0;
                end
            end
        end
    end

    // Timestamps are meaningless while a slot is free, so they skip reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (wr_en_i && wr_slot_i == SLOT_W'(i)) begin
                entry_time_q[i] <= wr_time_i;
            end
        end
    end

`ifdef PARK_OVERFLOW_EN
    logic [SLOTS-1:0] ovf_q;

    // A full lap of the time base returns now to the entry stamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_en_i && wr_slot_i == SLOT_W'(i)) begin
                    ovf_q[i] <= 1'b0;
                end else if (tick_i && occ_q[i] &&
                             (now_i + TIME_W'(1)) == entry_time_q[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        rd_time_o = '0;
        rd_occ_o  = 1'b0;
`ifdef PARK_OVERFLOW_EN
        rd_ovf_o  = 1'b0;
`endif
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_slot_i == SLOT_W'(i)) begin
                rd_time_o = entry_time_q[i];
                rd_occ_o  = occ_q[i];
`ifdef PARK_OVERFLOW_EN
                rd_ovf_o  = ovf_q[i];
`endif
            end
        end
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/time_calculate.sv
// Modulo-2^TIME_W subtractor shared by every exit transaction.
module time_calculate
    import parking_pkg::*;
(
    input  logic [TIME_W-1:0] time_out_i,
    input  logic [TIME_W-1:0] time_in_i,
    output logic [TIME_W-1:0] diff_o
);

    assign diff_o = time_out_i - time_in_i;

endmodule

// File: rtl/parking_time_scheduler.sv
// Parking controller scheduler: time base, slot allocation and exit duration sequencing.
// Define PARK_OVERFLOW_EN to saturate durations of a full lap or more and report dur_ovf.
module parking_time_scheduler
    import parking_pkg::*;
#(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    parking_time_scheduler_if.slave   bus
);

    localparam int CNT_W = SLOT_W + 1;

    park_state_e       state_q, state_d;
    logic [TIME_W-1:0] now_q, now_d;
    logic [TIME_W-1:0] time_in_q, time_out_q;
    logic [SLOT_W-1:0] slot_q;
    logic              bad_q;
    logic [TIME_W-1:0] dur_time_q, dur_d;
    logic [SLOT_W-1:0] dur_slot_q;

    logic [SLOTS-1:0]     occ;
    logic [MAX_SLOTS-1:0] occ_pad;
    logic [4:0]           free_idx;
    logic [SLOT_W-1:0]    free_slot;
    logic                 full;
    logic [CNT_W-1:0]     occ_cnt;
    logic [TIME_W-1:0]    rd_time;
    logic                 rd_occ;
    logic                 exit_bad;
    logic [TIME_W-1:0]    diff;

`ifdef PARK_OVERFLOW_EN
    logic rd_ovf;
    logic ovf_q;
    logic dur_ovf_q;
`endif

    parking_slot_table #(.SLOTS(SLOTS), .SLOT_W(SLOT_W)) u_table (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (state_q == ST_ENTRY),
        .wr_slot_i  (free_slot),
        .wr_time_i  (now_q),
        .clr_en_i   (state_q == ST_EXIT_SUB && !bad_q),
        .clr_slot_i (slot_q),
        .rd_slot_i  (bus.exit_slot),
        .occ_o      (occ),
        .rd_time_o  (rd_time),
`ifdef PARK_OVERFLOW_EN
        .tick_i     (bus.tick),
        .now_i      (now_q),
        .rd_ovf_o   (rd_ovf),
`endif
        .rd_occ_o   (rd_occ)
    );

    time_calculate u_sub (
        .time_out_i (time_out_q),
        .time_in_i  (time_in_q),
        .diff_o     (diff)
    );

    // Unused encoder inputs read as occupied so only real slots are ever chosen.
    always_comb begin
        occ_pad              = '1;
        occ_pad[SLOTS-1:0]   = occ;
        occ_cnt              = '0;
        for (int i = 0; i < SLOTS; i++) begin
            occ_cnt = occ_cnt + CNT_W'(occ[i]);
        end
    end

    assign free_idx  = lowest_free(occ_pad);
    assign free_slot = free_idx[SLOT_W-1:0];
    assign full      = (free_idx >= 5'(SLOTS));
    assign exit_bad  = (int'(bus.exit_slot) >= SLOTS) || !rd_occ;
    assign now_d     = bus.tick ? now_q + TIME_W'(1) : now_q;

`ifdef PARK_OVERFLOW_EN
    assign dur_d = ovf_q ? DUR_SAT : diff;
`else
    assign dur_d = diff;
`endif

    // Exit outranks entry in IDLE since it frees capacity.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.exit_req) begin
                    state_d = ST_EXIT_LOAD;
                end else if (bus.entry_req && !full) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY:     state_d = ST_IDLE;
            ST_EXIT_LOAD: state_d = ST_EXIT_SUB;
            ST_EXIT_SUB:  state_d = bad_q ? ST_IDLE : ST_OUT_WAIT;
            ST_OUT_WAIT: begin
                if (bus.dur_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            now_q      <= '0;
            time_in_q  <= '0;
            time_out_q <= '0;
            slot_q     <= '0;
            bad_q      <= 1'b0;
            dur_time_q <= '0;
            dur_slot_q <= '0;
`ifdef PARK_OVERFLOW_EN
            ovf_q      <= 1'b0;
            dur_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            now_q   <= now_d;
            if (state_q == ST_EXIT_LOAD) begin
                time_in_q  <= rd_time;
                time_out_q <= now_q;
                slot_q     <= bus.exit_slot;
                bad_q      <= exit_bad;
`ifdef PARK_OVERFLOW_EN
                ovf_q      <= rd_ovf;
`endif
            end
            if (state_q == ST_EXIT_SUB && !bad_q) begin
                dur_time_q <= dur_d;
                dur_slot_q <= slot_q;
`ifdef PARK_OVERFLOW_EN
                dur_ovf_q  <= ovf_q;
`endif
            end
        end
    end

    assign bus.entry_ack  = (state_q == ST_ENTRY);
    assign bus.entry_slot = (state_q == ST_ENTRY) ? free_slot : '0;
    assign bus.full       = full;
    assign bus.exit_ack   = (state_q == ST_EXIT_SUB);
    assign bus.exit_err   = (state_q == ST_EXIT_SUB) && bad_q;
    assign bus.dur_valid  = (state_q == ST_OUT_WAIT);
    assign bus.dur_time   = dur_time_q;
    assign bus.dur_slot   = dur_slot_q;
    assign bus.now        = now_q;
    assign bus.occupancy  = occ_cnt;
`ifdef PARK_OVERFLOW_EN
    assign bus.dur_ovf    = dur_ovf_q;
`endif

endmodule
